// File: rtl/ldtu_rx_pkg.sv
// Shared definitions for the LiTE-DTU serial lane receiver: word width,
// the idle/sync pattern the serializer sends when it has nothing to say,
// and the alignment state machine's states.
package ldtu_rx_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 32'hEAAAAAAA;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/ldtu_ser_rx_aligner.sv
// Receiver for one LiTE-DTU serial lane. Bits arrive MSB first, one per
// CLK_SRL cycle. The aligner hunts every bit phase for the sync word, confirms
// the phase over several consecutive boundary-aligned sync words, and once
// locked emits every recovered 32-bit word. Lock is dropped after too many
// consecutive non-sync words.
module ldtu_ser_rx_aligner
    import ldtu_rx_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD    = DEFAULT_SYNC_WORD,
    parameter int                SYNC_CONFIRM = 3,
    parameter int                LOCK_TIMEOUT = 1024
) (
    input  logic              CLK_SRL,
    input  logic              RST,
    input  logic              ser_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              is_idle,
    output logic              locked,
    output logic              lock_lost,
    output logic [7:0]        sync_err_cnt
);

    localparam int CONF_W = $clog2(SYNC_CONFIRM + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [CONF_W-1:0] CONF_TARGET = CONF_W'(SYNC_CONFIRM);
    localparam logic [TO_W-1:0]   TO_LIMIT    = TO_W'(LOCK_TIMEOUT);

    // The candidate word is the stored history plus the live input bit, so
    // only 31 bits of history ever need to be kept.
    logic [WORD_W-2:0] sr_q, sr_d;
    logic [WORD_W-1:0] cand_w;
    logic              cand_is_sync;

    rx_state_e         state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [CONF_W-1:0] conf_cnt_q, conf_cnt_d, conf_next;
    logic [TO_W-1:0]   timeout_cnt_q, timeout_cnt_d, timeout_next;

    logic [WORD_W-1:0] word_out_q, word_out_d;
    logic              word_valid_q, word_valid_d;
    logic              is_idle_q, is_idle_d;
    logic              locked_q, locked_d;
    logic              lock_lost_q, lock_lost_d;
    logic [7:0]        sync_err_cnt_q, sync_err_cnt_d, sync_err_inc;

    assign cand_w       = {sr_q, ser_in};
    assign cand_is_sync = (cand_w == SYNC_WORD);

    // Next-state and output logic: hunt every phase, verify on word
    // boundaries, and while locked emit each word and track missing syncs.
    always_comb begin
        sr_d           = cand_w[WORD_W-2:0];
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        conf_cnt_d     = conf_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        word_out_d     = word_out_q;
        word_valid_d   = 1'b0;
        is_idle_d      = is_idle_q;
        lock_lost_d    = 1'b0;
        sync_err_cnt_d = sync_err_cnt_q;
        conf_next      = conf_cnt_q + CONF_W'(1);
        timeout_next   = timeout_cnt_q + TO_W'(1);
        sync_err_inc   = (sync_err_cnt_q == 8'hFF) ? sync_err_cnt_q
                                                   : sync_err_cnt_q + 8'd1;

        unique case (state_q)
            HUNT: begin
                if (cand_is_sync) begin
                    state_d    = VERIFY;
                    bit_cnt_d  = 5'd0;
                    conf_cnt_d = CONF_W'(1);
                end
            end
            VERIFY: begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    if (cand_is_sync) begin
                        conf_cnt_d = conf_next;
                        if (conf_next == CONF_TARGET) begin
                            state_d       = LOCKED;
                            timeout_cnt_d = '0;
                        end
                    end else begin
                        state_d        = HUNT;
                        sync_err_cnt_d = sync_err_inc;
                    end
                end
            end
            LOCKED: begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    word_out_d   = cand_w;
                    word_valid_d = 1'b1;
                    is_idle_d    = cand_is_sync;
                    if (cand_is_sync) begin
                        timeout_cnt_d = '0;
                    end else begin
                        timeout_cnt_d = timeout_next;
                        if (timeout_next == TO_LIMIT) begin
                            state_d        = HUNT;
                            lock_lost_d    = 1'b1;
                            sync_err_cnt_d = sync_err_inc;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    // State and output registers; reset returns to HUNT with everything cleared.
    always_ff @(posedge CLK_SRL) begin
        if (RST) begin
            sr_q           <= '0;
            state_q        <= HUNT;
            bit_cnt_q      <= '0;
            conf_cnt_q     <= '0;
            timeout_cnt_q  <= '0;
            word_out_q     <= '0;
            word_valid_q   <= 1'b0;
            is_idle_q      <= 1'b0;
            locked_q       <= 1'b0;
            lock_lost_q    <= 1'b0;
            sync_err_cnt_q <= '0;
        end else begin
            sr_q           <= sr_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            conf_cnt_q     <= conf_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            word_out_q     <= word_out_d;
            word_valid_q   <= word_valid_d;
            is_idle_q      <= is_idle_d;
            locked_q       <= locked_d;
            lock_lost_q    <= lock_lost_d;
            sync_err_cnt_q <= sync_err_cnt_d;
        end
    end

    assign word_out     = word_out_q;
    assign word_valid   = word_valid_q;
    assign is_idle      = is_idle_q;
    assign locked       = locked_q;
    assign lock_lost    = lock_lost_q;
    assign sync_err_cnt = sync_err_cnt_q;

endmodule

// File: tb/tb_ldtu_ser_rx_aligner.sv
// Bench for the serial lane aligner. A behavioural model tracks how many bits
// have elapsed since the last sync match and decides word boundaries with
// modulo arithmetic; each scenario compares the DUT's per-cycle outputs with
// the model and checks scenario timing against values derived from stimulus.
module tb_ldtu_ser_rx_aligner;

    localparam logic [31:0] SYNC    = 32'hEAAAAAAA;
    localparam int          CONFIRM = 3;
    localparam int          TIMEOUT = 4;

    logic        CLK_SRL;
    logic        RST;
    logic        ser_in;
    logic [31:0] word_out;
    logic        word_valid;
    logic        is_idle;
    logic        locked;
    logic        lock_lost;
    logic [7:0]  sync_err_cnt;

    ldtu_ser_rx_aligner #(
        .SYNC_WORD   (SYNC),
        .SYNC_CONFIRM(CONFIRM),
        .LOCK_TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_SRL     (CLK_SRL),
        .RST         (RST),
        .ser_in      (ser_in),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .is_idle     (is_idle),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .sync_err_cnt(sync_err_cnt)
    );

    initial CLK_SRL = 1'b0;
    always #5 CLK_SRL = ~CLK_SRL;

    int n_checks;
    int n_pass;
    int cyc;
    int first_bad;

    // Behavioural model state
    logic [31:0] m_w;
    bit          m_hunting, m_confirming, m_locked;
    int          m_since, m_confirms, m_misses, m_err;
    logic [31:0] e_word;
    logic        e_valid, e_idle, e_lost, e_locked;

    // Per-cycle traces and DUT event logs
    logic [43:0] dut_trace[$];
    logic [43:0] exp_trace[$];
    logic [31:0] dut_words[$];
    logic        dut_idle[$];
    int          dut_valid_cyc[$];
    int          dut_lost_cyc[$];
    int          dut_rise_cyc[$];
    int          dut_fall_cyc[$];
    logic        prev_locked;

    task automatic model_step(input logic b, input logic r);
        if (r) begin
            m_w = '0; m_hunting = 1; m_confirming = 0; m_locked = 0;
            m_since = 0; m_confirms = 0; m_misses = 0; m_err = 0;
            e_word = '0; e_valid = 0; e_idle = 0; e_lost = 0; e_locked = 0;
        end else begin
            m_w = {m_w[30:0], b};
            e_valid = 0;
            e_lost = 0;
            if (m_hunting) begin
                if (m_w == SYNC) begin
                    m_hunting = 0; m_confirming = 1; m_since = 0; m_confirms = 1;
                end
            end else begin
                m_since++;
                if (m_since % 32 == 0) begin
                    if (m_confirming) begin
                        if (m_w == SYNC) begin
                            m_confirms++;
                            if (m_confirms == CONFIRM) begin
                                m_confirming = 0; m_locked = 1; m_misses = 0;
                            end
                        end else begin
                            m_confirming = 0; m_hunting = 1;
                            if (m_err < 255) m_err++;
                        end
                    end else begin
                        e_valid = 1; e_word = m_w; e_idle = (m_w == SYNC);
                        if (m_w == SYNC) m_misses = 0;
                        else m_misses++;
                        if (m_misses == TIMEOUT) begin
                            m_locked = 0; m_hunting = 1; e_lost = 1;
                            if (m_err < 255) m_err++;
                        end
                    end
                end
            end
            e_locked = m_locked;
        end
    endtask

    task automatic clear_logs();
        dut_trace.delete(); exp_trace.delete();
        dut_words.delete(); dut_idle.delete(); dut_valid_cyc.delete();
        dut_lost_cyc.delete(); dut_rise_cyc.delete(); dut_fall_cyc.delete();
    endtask

    task automatic tick(input logic b, input logic r);
        ser_in = b;
        RST    = r;
        @(posedge CLK_SRL);
        model_step(b, r);
        @(negedge CLK_SRL);
        cyc++;
        dut_trace.push_back({word_valid, is_idle, lock_lost, locked, sync_err_cnt, word_out});
        exp_trace.push_back({e_valid, e_idle, e_lost, e_locked, 8'(m_err), e_word});
        if (word_valid) begin
            dut_words.push_back(word_out);
            dut_idle.push_back(is_idle);
            dut_valid_cyc.push_back(cyc);
        end
        if (lock_lost) dut_lost_cyc.push_back(cyc);
        if (locked && !prev_locked) dut_rise_cyc.push_back(cyc);
        if (!locked && prev_locked) dut_fall_cyc.push_back(cyc);
        prev_locked = locked;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) tick(w[i], 1'b0);
    endtask

    task automatic test_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        n_checks++; if (word_out !== 32'h0) $display("[TB] FAIL reset_word_out got %h expected 0", word_out); else n_pass++;
        n_checks++; if (word_valid !== 1'b0) $display("[TB] FAIL reset_word_valid got %b expected 0", word_valid); else n_pass++;
        n_checks++; if (is_idle !== 1'b0) $display("[TB] FAIL reset_is_idle got %b expected 0", is_idle); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("[TB] FAIL reset_locked got %b expected 0", locked); else n_pass++;
        n_checks++; if (lock_lost !== 1'b0) $display("[TB] FAIL reset_lock_lost got %b expected 0", lock_lost); else n_pass++;
        n_checks++; if (sync_err_cnt !== 8'h0) $display("[TB] FAIL reset_sync_err_cnt got %0d expected 0", sync_err_cnt); else n_pass++;
    endtask

    task automatic test_sync_lock();
        int c0, match_cyc;
        tick(1'b0, 1'b1);
        clear_logs();
        c0 = cyc;
        for (int i = 0; i < 13; i++) tick(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 200; i++) send_word(SYNC);
        match_cyc = c0 + 13 + 32;
        n_checks++;
        if (dut_rise_cyc.size() != 1 || dut_rise_cyc[0] != match_cyc + 64)
            $display("[TB] FAIL sync_lock_rise got %0d rises first %0d expected one at %0d",
                     dut_rise_cyc.size(), (dut_rise_cyc.size() > 0) ? dut_rise_cyc[0] : -1, match_cyc + 64);
        else n_pass++;
        n_checks++;
        if (dut_words.size() != 197)
            $display("[TB] FAIL sync_lock_pulse_count got %0d expected 197", dut_words.size());
        else n_pass++;
        for (int i = 0; i < dut_words.size(); i++) begin
            n_checks++;
            if (dut_words[i] !== SYNC || dut_idle[i] !== 1'b1 || dut_valid_cyc[i] != match_cyc + 96 + 32 * i)
                $display("[TB] FAIL sync_lock_word[%0d] got %h idle %b at %0d expected %h idle 1 at %0d",
                         i, dut_words[i], dut_idle[i], dut_valid_cyc[i], SYNC, match_cyc + 96 + 32 * i);
            else n_pass++;
        end
        n_checks++; if (sync_err_cnt !== 8'd0) $display("[TB] FAIL sync_lock_err got %0d expected 0", sync_err_cnt); else n_pass++;
        first_bad = -1;
        for (int i = 0; i < dut_trace.size(); i++) if (first_bad < 0 && dut_trace[i] !== exp_trace[i]) first_bad = i;
        n_checks++;
        if (first_bad >= 0) $display("[TB] FAIL sync_lock_trace idx %0d got %h expected %h", first_bad, dut_trace[first_bad], exp_trace[first_bad]);
        else n_pass++;
    endtask

    task automatic test_data_words();
        int l1, l2;
        clear_logs();
        send_word(32'h12345678); l1 = cyc;
        send_word(32'h0BADF00D); l2 = cyc;
        send_word(SYNC);
        send_word(SYNC);
        n_checks++;
        if (dut_words.size() != 4 || dut_words[0] !== 32'h12345678 || dut_idle[0] !== 1'b0 || dut_valid_cyc[0] != l1)
            $display("[TB] FAIL data_word0 got %0d words first %h at %0d expected 12345678 idle 0 at %0d",
                     dut_words.size(), (dut_words.size() > 0) ? dut_words[0] : 32'h0, (dut_valid_cyc.size() > 0) ? dut_valid_cyc[0] : -1, l1);
        else n_pass++;
        n_checks++;
        if (dut_words.size() != 4 || dut_words[1] !== 32'h0BADF00D || dut_idle[1] !== 1'b0 || dut_valid_cyc[1] != l2)
            $display("[TB] FAIL data_word1 got %0d words expected 0badf00d idle 0 at %0d", dut_words.size(), l2);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b1 || dut_lost_cyc.size() != 0)
            $display("[TB] FAIL data_keep_lock got locked %b losses %0d expected 1 and 0", locked, dut_lost_cyc.size());
        else n_pass++;
        first_bad = -1;
        for (int i = 0; i < dut_trace.size(); i++) if (first_bad < 0 && dut_trace[i] !== exp_trace[i]) first_bad = i;
        n_checks++;
        if (first_bad >= 0) $display("[TB] FAIL data_trace idx %0d got %h expected %h", first_bad, dut_trace[first_bad], exp_trace[first_bad]);
        else n_pass++;
    endtask

    task automatic test_verify_fail();
        int c0;
        tick(1'b0, 1'b1);
        clear_logs();
        c0 = cyc;
        send_word(SYNC);
        send_word(SYNC);
        send_word(SYNC ^ 32'h0000_0020);
        n_checks++;
        if (sync_err_cnt !== 8'd1 || locked !== 1'b0)
            $display("[TB] FAIL verify_err got err %0d locked %b expected 1 and 0", sync_err_cnt, locked);
        else n_pass++;
        for (int i = 0; i < 5; i++) send_word(SYNC);
        n_checks++;
        if (dut_rise_cyc.size() != 1 || dut_rise_cyc[0] != c0 + 32 * 6)
            $display("[TB] FAIL verify_relock got %0d rises first %0d expected one at %0d",
                     dut_rise_cyc.size(), (dut_rise_cyc.size() > 0) ? dut_rise_cyc[0] : -1, c0 + 32 * 6);
        else n_pass++;
        n_checks++;
        if (dut_valid_cyc.size() != 2 || dut_valid_cyc[0] != c0 + 32 * 7)
            $display("[TB] FAIL verify_first_valid got %0d pulses first %0d expected 2 first at %0d",
                     dut_valid_cyc.size(), (dut_valid_cyc.size() > 0) ? dut_valid_cyc[0] : -1, c0 + 32 * 7);
        else n_pass++;
        first_bad = -1;
        for (int i = 0; i < dut_trace.size(); i++) if (first_bad < 0 && dut_trace[i] !== exp_trace[i]) first_bad = i;
        n_checks++;
        if (first_bad >= 0) $display("[TB] FAIL verify_trace idx %0d got %h expected %h", first_bad, dut_trace[first_bad], exp_trace[first_bad]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic [31:0] last_d;
        int l4;
        tick(1'b0, 1'b1);
        clear_logs();
        for (int i = 0; i < 4; i++) send_word(SYNC);
        last_d = '0;
        for (int i = 0; i < TIMEOUT; i++) begin
            d = $urandom;
            while (d == SYNC) d = $urandom;
            send_word(d);
            last_d = d;
        end
        l4 = cyc;
        n_checks++;
        if (dut_lost_cyc.size() != 1 || dut_lost_cyc[0] != l4)
            $display("[TB] FAIL timeout_lost got %0d pulses first %0d expected one at %0d",
                     dut_lost_cyc.size(), (dut_lost_cyc.size() > 0) ? dut_lost_cyc[0] : -1, l4);
        else n_pass++;
        n_checks++;
        if (dut_fall_cyc.size() != 1 || dut_fall_cyc[0] != l4)
            $display("[TB] FAIL timeout_locked_fall got %0d falls first %0d expected one at %0d",
                     dut_fall_cyc.size(), (dut_fall_cyc.size() > 0) ? dut_fall_cyc[0] : -1, l4);
        else n_pass++;
        n_checks++;
        if (dut_words.size() != 5 || dut_words[4] !== last_d || dut_valid_cyc[4] != l4)
            $display("[TB] FAIL timeout_last_word got %0d words expected 5 with last %h at %0d", dut_words.size(), last_d, l4);
        else n_pass++;
        n_checks++; if (sync_err_cnt !== 8'd1) $display("[TB] FAIL timeout_err got %0d expected 1", sync_err_cnt); else n_pass++;
        first_bad = -1;
        for (int i = 0; i < dut_trace.size(); i++) if (first_bad < 0 && dut_trace[i] !== exp_trace[i]) first_bad = i;
        n_checks++;
        if (first_bad >= 0) $display("[TB] FAIL timeout_trace idx %0d got %h expected %h", first_bad, dut_trace[first_bad], exp_trace[first_bad]);
        else n_pass++;
    endtask

    task automatic test_slip();
        int cs, n;
        tick(1'b0, 1'b1);
        clear_logs();
        for (int i = 0; i < 4; i++) send_word(SYNC);
        tick(1'b0, 1'b0);
        cs = cyc;
        for (int i = 0; i < 9; i++) send_word(SYNC);
        for (int i = 0; i < 3; i++) send_word(32'hCAFEC0DE);
        send_word(SYNC);
        n_checks++;
        if (dut_lost_cyc.size() != 1 || dut_lost_cyc[0] != cs + 32 * 4 - 1)
            $display("[TB] FAIL slip_lost got %0d pulses first %0d expected one at %0d",
                     dut_lost_cyc.size(), (dut_lost_cyc.size() > 0) ? dut_lost_cyc[0] : -1, cs + 32 * 4 - 1);
        else n_pass++;
        n_checks++;
        if (dut_rise_cyc.size() != 2 || dut_rise_cyc[1] != cs + 32 * 6)
            $display("[TB] FAIL slip_relock got %0d rises expected 2 with relock at %0d", dut_rise_cyc.size(), cs + 32 * 6);
        else n_pass++;
        n = dut_words.size();
        n_checks++;
        if (n < 4 || dut_words[n-4] !== 32'hCAFEC0DE || dut_words[n-3] !== 32'hCAFEC0DE ||
            dut_words[n-2] !== 32'hCAFEC0DE || dut_idle[n-2] !== 1'b0 || dut_words[n-1] !== SYNC || dut_idle[n-1] !== 1'b1)
            $display("[TB] FAIL slip_words got %0d words last %h expected cafec0de x3 then %h",
                     n, (n > 0) ? dut_words[n-1] : 32'h0, SYNC);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b1 || sync_err_cnt !== 8'd1)
            $display("[TB] FAIL slip_final got locked %b err %0d expected 1 and 1", locked, sync_err_cnt);
        else n_pass++;
        first_bad = -1;
        for (int i = 0; i < dut_trace.size(); i++) if (first_bad < 0 && dut_trace[i] !== exp_trace[i]) first_bad = i;
        n_checks++;
        if (first_bad >= 0) $display("[TB] FAIL slip_trace idx %0d got %h expected %h", first_bad, dut_trace[first_bad], exp_trace[first_bad]);
        else n_pass++;
    endtask

    task automatic test_reset_midlock();
        logic [31:0] s;
        int c;
        s = SYNC;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_word(SYNC);
        clear_logs();
        send_word(SYNC);
        for (int i = 31; i >= 16; i--) tick(s[i], 1'b0);
        n_checks++; if (locked !== 1'b1) $display("[TB] FAIL midlock_before got locked %b expected 1", locked); else n_pass++;
        tick(1'($urandom_range(0, 1)), 1'b1);
        n_checks++;
        if ({word_out, word_valid, is_idle, locked, lock_lost, sync_err_cnt} !== 44'h0)
            $display("[TB] FAIL midlock_reset got word %h valid %b idle %b locked %b lost %b err %0d expected all 0",
                     word_out, word_valid, is_idle, locked, lock_lost, sync_err_cnt);
        else n_pass++;
        c = cyc;
        for (int i = 0; i < 5; i++) send_word(SYNC);
        n_checks++;
        if (dut_rise_cyc.size() != 1 || dut_rise_cyc[0] != c + 32 + 64)
            $display("[TB] FAIL midlock_relock got %0d rises first %0d expected one at %0d",
                     dut_rise_cyc.size(), (dut_rise_cyc.size() > 0) ? dut_rise_cyc[0] : -1, c + 96);
        else n_pass++;
        n_checks++;
        if (dut_valid_cyc.size() < 2 || dut_valid_cyc[dut_valid_cyc.size()-2] != c + 128)
            $display("[TB] FAIL midlock_first_valid got %0d pulses expected first post-reset pulse at %0d", dut_valid_cyc.size(), c + 128);
        else n_pass++;
        first_bad = -1;
        for (int i = 0; i < dut_trace.size(); i++) if (first_bad < 0 && dut_trace[i] !== exp_trace[i]) first_bad = i;
        n_checks++;
        if (first_bad >= 0) $display("[TB] FAIL midlock_trace idx %0d got %h expected %h", first_bad, dut_trace[first_bad], exp_trace[first_bad]);
        else n_pass++;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        cyc         = 0;
        prev_locked = 1'b0;
        RST         = 1'b1;
        ser_in      = 1'b0;
        model_step(1'b0, 1'b1);
        $display("[TB] starting ldtu_ser_rx_aligner bench");
        test_reset();
        test_sync_lock();
        test_data_words();
        test_verify_fail();
        test_timeout();
        test_slip();
        test_reset_midlock();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
